// File: rtl/flappy_pkg.sv
// Shared Flappy constants and the game state encoding used by the scroller, VGA stage and bird logic.
package flappy_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int PIPE_W    = 80;
    localparam int BIRD_X    = 160;
    localparam int SPACING   = 160;
    localparam int NUM_PIPES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Start-of-game left edge of pipe idx: the first pipe sits two pitches in.
    function automatic logic [9:0] pipe_home_x(input int idx, input int spacing);
        return 10'((idx + 2) * spacing);
    endfunction

endpackage

// File: rtl/pipe_scroller_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left one step per enabled cycle.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        feedback;

    always_comb begin
        feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
        state_d  = en ? {state_q[14:0], feedback} : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls and recycles the four Flappy pipe columns and counts pipes passed.
// Optional: define PIPE_SPEEDUP_EN to raise the scroll step with the score.
module pipe_scroller #(
    parameter int          SCREEN_W  = flappy_pkg::SCREEN_W,
    parameter int          SPACING   = flappy_pkg::SPACING,
    parameter int          PIPE_W    = flappy_pkg::PIPE_W,
    parameter int          STEP      = 2,
    parameter int          STEP_MAX  = 6,
    parameter int          BIRD_X    = flappy_pkg::BIRD_X,
    parameter int          GAP_MIN   = 120,
    parameter int          GAP_RANGE = 256,
    parameter int          Y_INIT    = 240,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       ClkPort,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       crash,
    output logic [9:0] X_Edge_O1,
    output logic [9:0] X_Edge_O2,
    output logic [9:0] X_Edge_O3,
    output logic [9:0] X_Edge_O4,
    output logic [9:0] Y_Edge_O1,
    output logic [9:0] Y_Edge_O2,
    output logic [9:0] Y_Edge_O3,
    output logic [9:0] Y_Edge_O4,
    output logic [7:0] score,
    output logic       score_tick,
    output logic       running
);

    import flappy_pkg::*;

    localparam logic [10:0] SCREEN_W11 = 11'(SCREEN_W);
    localparam logic [10:0] PIPE_W11   = 11'(PIPE_W);
    localparam logic [10:0] BIRD_X11   = 11'(BIRD_X);
    localparam logic [15:0] GAP_MIN16  = 16'(GAP_MIN);
    localparam logic [15:0] GAP_MASK16 = 16'(GAP_RANGE - 1);
    localparam logic [9:0]  Y_INIT10   = 10'(Y_INIT);

    if (STEP_MAX < STEP || LFSR_SEED == 16'h0000 || GAP_RANGE > 256 ||
        (GAP_RANGE & (GAP_RANGE - 1)) != 0) begin : g_param_check
        $error("pipe_scroller: inconsistent parameter set");
    end

    state_t      state_q, state_d;
    logic        load_layout, do_move;
    logic        running_q, running_d;
    logic [9:0]  x_q [NUM_PIPES];
    logic [9:0]  x_d [NUM_PIPES];
    logic [9:0]  y_q [NUM_PIPES];
    logic [9:0]  y_d [NUM_PIPES];
    logic [7:0]  score_q, score_d;
    logic        score_tick_q, score_tick_d;
    logic [15:0] lfsr_state;
    logic [10:0] step;
    logic [10:0] gap_y;
    logic        any_pass;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (ClkPort),
        .rst_n (reset_n),
        .en    (do_move),
        .state (lfsr_state)
    );

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (crash) state_d = FROZEN;
            FROZEN:  if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // crash outranks frame_tick, so a crashing frame never moves or scores.
    always_comb begin
        load_layout = (state_q != RUN) && start;
        do_move     = (state_q == RUN) && frame_tick && !crash;
        running_d   = (state_d == RUN);
    end

`ifdef PIPE_SPEEDUP_EN
    logic [10:0] step_raw;
    always_comb begin
        step_raw = 11'(STEP) + {6'd0, score_q[7:3]};
        step     = (step_raw > 11'(STEP_MAX)) ? 11'(STEP_MAX) : step_raw;
    end
`else
    assign step = 11'(STEP);
`endif

    always_comb begin
        logic [10:0] x_old, x_mv, x_rc;
        // Mask over the full LFSR word; GAP_RANGE <= 256 keeps only lfsr[7:0].
        gap_y        = 11'(GAP_MIN16 + (lfsr_state & GAP_MASK16));
        any_pass     = 1'b0;
        score_d      = score_q;
        score_tick_d = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            x_old  = {1'b0, x_q[i]};
            x_mv   = x_old - step;
            x_rc   = x_old + SCREEN_W11 - step;
            if (load_layout) begin
                x_d[i] = pipe_home_x(i, SPACING);
                y_d[i] = Y_INIT10;
            end else if (do_move) begin
                if (x_old < step) begin
                    x_d[i] = 10'(x_rc);
                    y_d[i] = 10'(gap_y);
                end else begin
                    x_d[i] = 10'(x_mv);
                    if ((x_old + PIPE_W11 >= BIRD_X11) && (x_mv + PIPE_W11 < BIRD_X11)) begin
                        any_pass = 1'b1;
                    end
                end
            end
        end
        if (load_layout) begin
            score_d = 8'd0;
        end else if (do_move && any_pass) begin
            score_d      = sat_inc8(score_q);
            score_tick_d = (score_d != score_q);
        end
    end

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            running_q    <= 1'b0;
            score_q      <= 8'd0;
            score_tick_q <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i] <= pipe_home_x(i, SPACING);
                y_q[i] <= Y_INIT10;
            end
        end else begin
            running_q    <= running_d;
            score_q      <= score_d;
            score_tick_q <= score_tick_d;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign X_Edge_O1  = x_q[0];
    assign X_Edge_O2  = x_q[1];
    assign X_Edge_O3  = x_q[2];
    assign X_Edge_O4  = x_q[3];
    assign Y_Edge_O1  = y_q[0];
    assign Y_Edge_O2  = y_q[1];
    assign Y_Edge_O3  = y_q[2];
    assign Y_Edge_O4  = y_q[3];
    assign score      = score_q;
    assign score_tick = score_tick_q;
    assign running    = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: reset, scrolling, scoring, recycle, crash/restart, async reset.
module tb_pipe_scroller;

    logic       clk;
    logic       reset_n;
    logic       frame_tick;
    logic       start;
    logic       crash;
    logic [9:0] x1, x2, x3, x4;
    logic [9:0] y1, y2, y3, y4;
    logic [7:0] score;
    logic       score_tick;
    logic       running;

    int          checks;
    int          failures;
    int          pulses;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_used;

    pipe_scroller dut (
        .ClkPort    (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start      (start),
        .crash      (crash),
        .X_Edge_O1  (x1),
        .X_Edge_O2  (x2),
        .X_Edge_O3  (x3),
        .X_Edge_O4  (x4),
        .Y_Edge_O1  (y1),
        .Y_Edge_O2  (y2),
        .Y_Edge_O3  (y3),
        .Y_Edge_O4  (y4),
        .score      (score),
        .score_tick (score_tick),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One frame: frame_tick (plus optional start/crash) sampled on one rising edge.
    task automatic do_tick(input logic s, input logic c, input logic adv);
        @(negedge clk);
        frame_tick = 1'b1;
        start      = s;
        crash      = c;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        crash      = 1'b0;
        if (adv) begin
            lfsr_used = lfsr_m;
            lfsr_m    = lfsr_next(lfsr_m);
        end
        if (score_tick) pulses++;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        pulses     = 0;
        lfsr_m     = 16'hACE1;
        lfsr_used  = 16'h0000;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        crash      = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;

        check_eq("rst_x1", 32'(x1), 320);
        check_eq("rst_x2", 32'(x2), 480);
        check_eq("rst_x3", 32'(x3), 640);
        check_eq("rst_x4", 32'(x4), 800);
        check_eq("rst_y1", 32'(y1), 240);
        check_eq("rst_y4", 32'(y4), 240);
        check_eq("rst_score", 32'(score), 0);
        check_eq("rst_tick", 32'(score_tick), 0);
        check_eq("rst_running", 32'(running), 0);

        do_tick(1'b0, 1'b0, 1'b0);
        check_eq("idle_hold_x1", 32'(x1), 320);
        check_eq("idle_running", 32'(running), 0);

        do_tick(1'b1, 1'b0, 1'b0);
        check_eq("start_tick_running", 32'(running), 1);
        check_eq("start_tick_nomove_x1", 32'(x1), 320);
        check_eq("start_tick_nomove_x4", 32'(x4), 800);

        pulses = 0;
        do_tick(1'b0, 1'b0, 1'b1);
        check_eq("t1_x1", 32'(x1), 318);
        check_eq("t1_x2", 32'(x2), 478);
        check_eq("t1_x3", 32'(x3), 638);
        check_eq("t1_x4", 32'(x4), 798);
        check_eq("t1_y2", 32'(y2), 240);
        check_eq("t1_y3", 32'(y3), 240);
        check_eq("t1_score", 32'(score), 0);

        for (int k = 2; k <= 120; k++) do_tick(1'b0, 1'b0, 1'b1);
        check_eq("t120_x1", 32'(x1), 80);
        check_eq("t120_score", 32'(score), 0);
        check_eq("t120_pulses", 32'(pulses), 0);

        do_tick(1'b0, 1'b0, 1'b1);
        check_eq("t121_x1", 32'(x1), 78);
        check_eq("t121_score", 32'(score), 1);
        check_eq("t121_tick", 32'(score_tick), 1);
        @(posedge clk);
        #1;
        check_eq("t121_tick_onecycle", 32'(score_tick), 0);

        for (int k = 122; k <= 160; k++) do_tick(1'b0, 1'b0, 1'b1);
        check_eq("t160_x1", 32'(x1), 0);
        do_tick(1'b0, 1'b0, 1'b1);
        check_eq("recycle_x1", 32'(x1), 638);
        check_eq("recycle_y1", 32'(y1), 32'(120 + int'(lfsr_used[7:0])));
        check_eq("recycle_x2", 32'(x2), 158);
        check_eq("recycle_y2", 32'(y2), 240);
        check_eq("recycle_pulses", 32'(pulses), 1);

        do_tick(1'b0, 1'b1, 1'b0);
        check_eq("crash_running", 32'(running), 0);
        check_eq("crash_x1", 32'(x1), 638);
        check_eq("crash_x2", 32'(x2), 158);
        check_eq("crash_score", 32'(score), 1);
        do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        check_eq("frozen_x1", 32'(x1), 638);
        check_eq("frozen_x3", 32'(x3), 318);

        pulse_start();
        check_eq("restart_running", 32'(running), 1);
        check_eq("restart_x1", 32'(x1), 320);
        check_eq("restart_x4", 32'(x4), 800);
        check_eq("restart_y1", 32'(y1), 240);
        check_eq("restart_score", 32'(score), 0);

        pulses = 0;
        do_tick(1'b1, 1'b0, 1'b1);
        check_eq("start_in_run_x1", 32'(x1), 318);
        check_eq("start_in_run_running", 32'(running), 1);
        for (int k = 2; k <= 441; k++) begin
            do_tick(1'b0, 1'b0, 1'b1);
            if (k == 161) begin
                check_eq("run2_recycle_x1", 32'(x1), 638);
                check_eq("run2_recycle_y1", 32'(y1), 32'(120 + int'(lfsr_used[7:0])));
            end
        end
        check_eq("run2_x1", 32'(x1), 78);
        check_eq("run2_score", 32'(score), 5);
        check_eq("run2_pulses", 32'(pulses), 5);

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_x1", 32'(x1), 320);
        check_eq("arst_x2", 32'(x2), 480);
        check_eq("arst_x3", 32'(x3), 640);
        check_eq("arst_x4", 32'(x4), 800);
        check_eq("arst_y1", 32'(y1), 240);
        check_eq("arst_score", 32'(score), 0);
        check_eq("arst_tick", 32'(score_tick), 0);
        check_eq("arst_running", 32'(running), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_tick(1'b0, 1'b0, 1'b0);
        check_eq("post_rst_idle_x1", 32'(x1), 320);
        check_eq("post_rst_idle_running", 32'(running), 0);
        pulse_start();
        check_eq("post_rst_start_running", 32'(running), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Obstacle generator for the Flappy game: owns the four pipe columns, scrolls them left once per video frame, recycles each pipe at the right edge with a new pseudo-random gap height, and counts pipes the bird has passed. Sits directly upstream of the VGA output stage and drives its `X_Edge_O1..4` / `Y_Edge_O1..4` inputs. It also feeds the score display and the collision logic.

## Interface
- `SCREEN_W`, 640: visible width; recycle distance is 4×`SPACING`, which equals `SCREEN_W`.
- `SPACING`, 160: horizontal pitch between consecutive pipes.
- `PIPE_W`, 80: pipe width, used for score detection.
- `STEP`, 2: base pixels moved per frame.
- `STEP_MAX`, 6: step ceiling (speed-up only).
- `BIRD_X`, 160: bird's fixed X position.
- `GAP_MIN`, 120: minimum gap edge Y.
- `GAP_RANGE`, 256: gap Y span; must be a power of two ≤ 256.
- `Y_INIT`, 240: gap Y loaded at reset and at restart.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `ClkPort` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame (from vsync).
- `start` in 1: level-sampled request to begin or restart.
- `crash` in 1: collision flag from the bird logic.
- `X_Edge_O1..X_Edge_O4` out 10: pipe left edges, unsigned.
- `Y_Edge_O1..Y_Edge_O4` out 10: gap edge Y, unsigned.
- `score` out 8: pipes passed; saturates at 255.
- `score_tick` out 1: one-cycle pulse when `score` increments.
- `running` out 1: high in state RUN.

## Operation
- States: IDLE, RUN, FROZEN. Reset enters IDLE.
- IDLE → RUN on `start`. RUN → FROZEN on `crash`. FROZEN → RUN on `start`.
- Layout reload: entering RUN from IDLE or FROZEN loads X = 320, 480, 640, 800 and Y = `Y_INIT` for all pipes, and clears `score`. The LFSR is not reseeded.
- Movement: only in RUN, on `frame_tick`. Each pipe does X ← X − step. If X < step, the pipe recycles instead: X ← X + `SCREEN_W` − step, Y ← `GAP_MIN` + (lfsr[7:0] & (`GAP_RANGE`−1)).
- At most one pipe recycles per tick because `SPACING` > `STEP_MAX`. The LFSR advances once per RUN `frame_tick`, after its value has been sampled.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left.
- Score: when a pipe moves (not recycles) and satisfies old X+`PIPE_W` ≥ `BIRD_X` and new X+`PIPE_W` < `BIRD_X`, `score` increments (saturating) and `score_tick` pulses.
- Arithmetic: all sums are computed 11 bits wide. Every X stays ≤ 1023.
- In IDLE and FROZEN, positions, Y, score and LFSR hold.

## Timing
- Reset values: X = 320/480/640/800; Y = `Y_INIT`; `score` = 0; `score_tick` = 0; `running` = 0; LFSR = `LFSR_SEED`.
- All outputs are registered. Positions update on the clock edge that samples `frame_tick`, so they are visible the next cycle. `score_tick` is coincident with that update.
- `start` and `frame_tick` in the same cycle outside RUN: the state transition and reload happen; no movement that frame.
- `crash` and `frame_tick` in the same cycle in RUN: `crash` wins. Enter FROZEN, no movement, no score.
- `start` asserted while in RUN is ignored.
- `reset_n` low mid-frame: immediate asynchronous return to the reset values. Release is synchronised by the surrounding top level.

## Configuration
- `PIPE_SPEEDUP_EN` defined: step = min(`STEP` + (score >> 3), `STEP_MAX`), evaluated from the registered score.
- `PIPE_SPEEDUP_EN` undefined: step is constant `STEP`, and `STEP_MAX` is unused.

## Structure
- Shared package `flappy_pkg`: screen constants (640×480), `PIPE_W`, `BIRD_X`, and the state encoding `IDLE`=2'd0, `RUN`=2'd1, `FROZEN`=2'd2. The VGA stage and bird logic use the same package.
- Sub-module `lfsr16`: enable input, seed parameter, 16-bit state output.

## Test plan
- Reset, then `start`, then 1 `frame_tick` → X = 318/478/638/798; Y all 240; `score` = 0.
- From start, 121 ticks → pipe 1 at X = 78; `score` = 1; `score_tick` pulses on tick 121 only (X = 80 at tick 120 does not score).
- Pipe 1 at X = 1, one tick → X = 639; Y = 120 + (lfsr[7:0] at that tick); the LFSR advances by exactly one step.
- `crash` together with `frame_tick` → state FROZEN, X unchanged. Further ticks change nothing. `start` → layout reloaded, `score` = 0, `running` = 1.
- `PIPE_SPEEDUP_EN` defined, `score` = 8 → step 3. `score` = 40 → step 6 (capped). Without the macro, step is 2 at any score.
- `reset_n` pulsed low mid-run with `score` = 5 → all outputs return to reset values asynchronously; state IDLE.
